// File: rtl/mmcm_lock_ctrl.sv
//==============================================================================
// Module      : mmcm_lock_ctrl
// Description : MMCM reset/lock bring-up sequencer with lock timeout, stability
//               qualification, bounded retries and lock-loss re-sequencing.
//               Optional lock-loss counter enabled by MMCM_LOCK_LOSS_CNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mmcm_lock_ctrl #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmcm_locked,
    input  logic        restart,
    output logic        mmcm_rst,
    output logic        clk_ok,
    output logic        fail,
    output logic [7:0]  retry_cnt,
`ifdef MMCM_LOCK_LOSS_CNT_EN
    output logic [15:0] lock_loss_cnt,
`endif
    output logic [2:0]  state
);

    localparam int c_max_ab  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                               RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int c_max_cyc = (c_max_ab > LOCK_STABLE_CYCLES) ? c_max_ab : LOCK_STABLE_CYCLES;
    localparam int c_timer_w = (c_max_cyc > 2) ? $clog2(c_max_cyc) : 1;

    localparam logic [c_timer_w-1:0] c_hold_last    = c_timer_w'(RST_HOLD_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_stable_last  = c_timer_w'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RST_ASSERT = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    logic                 r_lock_meta;
    logic                 r_locked_s;
    state_t               r_state;
    logic [c_timer_w-1:0] r_timer;
    logic [7:0]           r_retry;

    state_t               w_state_nxt;
    logic [c_timer_w-1:0] w_timer_nxt;
    logic [7:0]           w_retry_nxt;
    logic [7:0]           w_retry_inc;
    logic                 w_attempt_fail;

    // Timer defaults to zero so that every state change clears it; only
    // RST_ASSERT, WAIT_LOCK and STABLE keep counting while they persist.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = '0;
        w_retry_nxt    = r_retry;
        w_attempt_fail = 1'b0;
        w_retry_inc    = (r_retry == 8'hFF) ? 8'hFF : r_retry + 8'd1;

        if (restart) begin
            w_state_nxt = ST_RST_ASSERT;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                ST_RST_ASSERT: begin
                    if (r_timer == c_hold_last) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_locked_s) begin
                        w_state_nxt = ST_STABLE;
                    end else if (r_timer == c_timeout_last) begin
                        w_attempt_fail = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!r_locked_s) begin
                        w_attempt_fail = 1'b1;
                    end else if (r_timer == c_stable_last) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!r_locked_s) begin
                        w_state_nxt = ST_RST_ASSERT;
                    end
                end
                ST_FAIL: begin
                    w_state_nxt = ST_FAIL;
                end
                default: begin
                    w_state_nxt = ST_RST_ASSERT;
                end
            endcase

            if (w_attempt_fail) begin
                w_retry_nxt = w_retry_inc;
                if ((MAX_RETRIES != 0) && (int'(w_retry_inc) == MAX_RETRIES)) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_state_nxt = ST_RST_ASSERT;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_locked_s  <= 1'b0;
            r_state     <= ST_RST_ASSERT;
            r_timer     <= '0;
            r_retry     <= '0;
            mmcm_rst    <= 1'b1;
            clk_ok      <= 1'b0;
            fail        <= 1'b0;
        end else begin
            r_lock_meta <= mmcm_locked;
            r_locked_s  <= r_lock_meta;
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_retry     <= w_retry_nxt;
            mmcm_rst    <= (w_state_nxt == ST_RST_ASSERT) || (w_state_nxt == ST_FAIL);
            clk_ok      <= (w_state_nxt == ST_RUN);
            fail        <= (w_state_nxt == ST_FAIL);
        end
    end

    assign state     = r_state;
    assign retry_cnt = r_retry;

`ifdef MMCM_LOCK_LOSS_CNT_EN
    logic [15:0] r_loss_cnt;

    // Only a genuine lock loss from RUN counts; restart has priority over it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if ((r_state == ST_RUN) && !r_locked_s && !restart &&
                     (r_loss_cnt != 16'hFFFF)) begin
            r_loss_cnt <= r_loss_cnt + 16'd1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mmcm_lock_ctrl.sv
//==============================================================================
// Module      : tb_mmcm_lock_ctrl
// Description : Self-checking bench for mmcm_lock_ctrl: directed bring-up
//               scenarios plus randomized lock/restart/reset traffic.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mmcm_lock_ctrl;

    localparam int HOLD  = 4;
    localparam int TOUT  = 32;
    localparam int STAB  = 8;
    localparam int MAXR  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mmcm_locked = 1'b0;
    logic        restart = 1'b0;
    logic        mmcm_rst;
    logic        clk_ok;
    logic        fail;
    logic [7:0]  retry_cnt;
    logic [2:0]  state;
`ifdef MMCM_LOCK_LOSS_CNT_EN
    logic [15:0] lock_loss_cnt;
`endif

    mmcm_lock_ctrl #(
        .RST_HOLD_CYCLES     (HOLD),
        .LOCK_TIMEOUT_CYCLES (TOUT),
        .LOCK_STABLE_CYCLES  (STAB),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mmcm_locked   (mmcm_locked),
        .restart       (restart),
        .mmcm_rst      (mmcm_rst),
        .clk_ok        (clk_ok),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
`ifdef MMCM_LOCK_LOSS_CNT_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference: phase (debug code), cycles spent in that phase, attempt and
    // loss tallies, plus a two-deep history of sampled LOCKED.
    int m_phase   = 0;
    int m_elapsed = 0;
    int m_retries = 0;
    int m_losses  = 0;
    bit m_hist1   = 1'b0;
    bit m_hist2   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_attempt_failed();
        m_retries = (m_retries < 255) ? m_retries + 1 : 255;
        m_phase   = (MAXR != 0 && m_retries == MAXR) ? 4 : 0;
        m_elapsed = 0;
    endtask

    task automatic model_step();
        bit seen;
        seen    = m_hist2;
        m_hist2 = m_hist1;
        m_hist1 = mmcm_locked;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_retries = 0; m_losses = 0;
            m_hist1 = 1'b0; m_hist2 = 1'b0;
        end else if (restart) begin
            m_phase = 0; m_elapsed = 0; m_retries = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_elapsed++;
                    if (m_elapsed == HOLD) begin m_phase = 1; m_elapsed = 0; end
                end
                1: begin
                    if (seen) begin
                        m_phase = 2; m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == TOUT) m_attempt_failed();
                    end
                end
                2: begin
                    if (!seen) begin
                        m_attempt_failed();
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == STAB) begin m_phase = 3; m_elapsed = 0; m_retries = 0; end
                    end
                end
                3: begin
                    if (!seen) begin
                        m_phase = 0; m_elapsed = 0;
                        if (m_losses < 65535) m_losses++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state",     {29'd0, state},               m_phase);
            check("mmcm_rst",  {31'd0, mmcm_rst},            (m_phase == 0 || m_phase == 4) ? 1 : 0);
            check("clk_ok",    {31'd0, clk_ok},              (m_phase == 3) ? 1 : 0);
            check("fail",      {31'd0, fail},                (m_phase == 4) ? 1 : 0);
            check("retry_cnt", {24'd0, retry_cnt},           m_retries);
`ifdef MMCM_LOCK_LOSS_CNT_EN
            check("lock_loss_cnt", {16'd0, lock_loss_cnt},   m_losses);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_state(input int tgt, input int budget, output int cyc);
        cyc = 0;
        while (state !== 3'(tgt) && cyc < budget) begin
            tick();
            cyc++;
        end
        if (state !== 3'(tgt)) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_state: got state %0d expected %0d within %0d cycles", state, tgt, budget);
        end
    endtask

    initial begin
        int n;
        int hold_left;

        tick();
        chk_en = 1'b1;
        tick();
        check("rst_state",    {29'd0, state},    0);
        check("rst_mmcm_rst", {31'd0, mmcm_rst}, 1);
        check("rst_clk_ok",   {31'd0, clk_ok},   0);
        check("rst_retry",    {24'd0, retry_cnt}, 0);

        // Clean bring-up: LOCKED rises one cycle after reset release.
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) mmcm_locked = 1'b1;
        end while (mmcm_rst && n < 50);
        check("t1_rst_hold", n, HOLD);
        wait_state(2, 20, n);
        n = 0;
        do begin tick(); n++; end while (!clk_ok && n < 50);
        check("t1_stable_len", n, STAB);
        check("t1_retry", {24'd0, retry_cnt}, 0);

        // Lock loss in RUN for 5 cycles.
        mmcm_locked = 1'b0;
        n = 0;
        do begin tick(); n++; end while (clk_ok && n < 20);
        check("t3_loss_latency", n, 3);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 2) mmcm_locked = 1'b1;
        end while (mmcm_rst && n < 50);
        check("t3_rst_hold", n, HOLD);
        wait_state(3, 100, n);
        check("t3_retry", {24'd0, retry_cnt}, 0);
`ifdef MMCM_LOCK_LOSS_CNT_EN
        check("t3_loss_cnt", {16'd0, lock_loss_cnt}, 1);
`endif

        // Lock drop seen while the stability timer is at 5.
        restart = 1'b1; tick(); restart = 1'b0;
        wait_state(2, 50, n);
        repeat (3) tick();
        mmcm_locked = 1'b0;
        wait_state(0, 10, n);
        check("t4_drop_cycles", n, 3);
        check("t4_retry", {24'd0, retry_cnt}, 1);
        mmcm_locked = 1'b1;
        wait_state(3, 100, n);
        check("t4_retry_after", {24'd0, retry_cnt}, 0);

        // LOCKED never comes: three timed-out attempts end in FAIL.
        mmcm_locked = 1'b0;
        restart = 1'b1; tick(); restart = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!fail && n < 300);
        check("t2_time_to_fail", n, MAXR * (HOLD + TOUT));
        check("t2_retry",    {24'd0, retry_cnt}, MAXR);
        check("t2_mmcm_rst", {31'd0, mmcm_rst},  1);
        repeat (1000) tick();
        check("t2_still_fail", {29'd0, state}, 4);

        // Restart out of FAIL.
        restart = 1'b1; tick(); restart = 1'b0;
        check("t5_fail",  {31'd0, fail},      0);
        check("t5_retry", {24'd0, retry_cnt}, 0);
        check("t5_state", {29'd0, state},     0);
`ifdef MMCM_LOCK_LOSS_CNT_EN
        check("t5_loss_cnt", {16'd0, lock_loss_cnt}, 1);
`endif
        n = 0;
        do begin tick(); n++; end while (mmcm_rst && n < 50);
        check("t5_rst_hold", n, HOLD);

        // Restart coincident with the third timeout.
        n = 0;
        while (!(state == 3'd1 && retry_cnt == 8'd2) && n < 200) begin tick(); n++; end
        check("t6_reached", {24'd0, retry_cnt}, 2);
        repeat (TOUT - 1) tick();
        restart = 1'b1; tick(); restart = 1'b0;
        check("t6_state", {29'd0, state},     0);
        check("t6_retry", {24'd0, retry_cnt}, 0);
        check("t6_fail",  {31'd0, fail},      0);

        // Random traffic against the reference.
        hold_left = 0;
        for (int i = 0; i < 5000; i++) begin
            if (hold_left == 0) begin
                mmcm_locked = ($urandom_range(0, 3) != 0);
                hold_left   = $urandom_range(1, 60);
            end else begin
                hold_left--;
            end
            restart = ($urandom_range(0, 199) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        restart = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
